// File: rtl/mem_align_unit.sv
// MEM-stage data access unit: formats narrow stores into byte lanes, runs one
// req/ack bus transaction, and extracts/extends narrow load results.
module mem_align_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_wr,
  input  logic [1:0]  size,
  input  logic        load_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic        cap_wr, cap_signed;
  logic [1:0]  cap_size, cap_lo;
  logic        misaligned;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] load_val;
  logic [7:0]  lane8;
  logic [15:0] lane16;

  // Store formatting uses the live inputs so it can be registered at accept.
  always_comb begin
    misaligned = (size == 2'b11) ||
                 (size == 2'b01 && addr[0]) ||
                 (size == 2'b10 && addr[1:0] != 2'b00);
    fmt_wdata  = wdata;
    fmt_be     = 4'b1111;
    case (size)
      2'b00: begin
        fmt_wdata = {4{wdata[7:0]}};
        fmt_be    = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{wdata[15:0]}};
        fmt_be    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!mem_wr) fmt_be = 4'b1111;
  end

  always_comb begin
    lane8    = bus_rdata[{cap_lo, 3'b000} +: 8];
    lane16   = bus_rdata[{cap_lo[1], 4'b0000} +: 16];
    load_val = bus_rdata;
    case (cap_size)
      2'b00:   load_val = {{24{cap_signed & lane8[7]}}, lane8};
      2'b01:   load_val = {{16{cap_signed & lane16[15]}}, lane16};
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = misaligned ? ERR : REQ;
      REQ: begin
        if (bus_ack)              state_next = DONE;
        else if (cnt == CNT_LAST) state_next = ERR;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      if (state == IDLE)                  cnt <= 8'd0;
      else if (state == REQ && !bus_ack)  cnt <= cnt + 8'd1;
    end
  end

  // Bus fields are frozen from accept until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_wr     <= 1'b0;
      cap_signed <= 1'b0;
      cap_size   <= 2'b00;
      cap_lo     <= 2'b00;
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_be     <= 4'd0;
      bus_wdata  <= 32'd0;
      rdata      <= 32'd0;
    end else begin
      if (state == IDLE && start) begin
        cap_wr     <= mem_wr;
        cap_signed <= load_signed;
        cap_size   <= size;
        cap_lo     <= addr[1:0];
        bus_we     <= mem_wr;
        bus_addr   <= {addr[31:2], 2'b00};
        bus_be     <= fmt_be;
        bus_wdata  <= fmt_wdata;
      end
      if (state == REQ && bus_ack && !cap_wr) rdata <= load_val;
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE) || (state == ERR);
  assign err     = (state == ERR);
  assign bus_req = (state == REQ);

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed self-checking bench for mem_align_unit; a second instance with
// TIMEOUT=4 exercises the timeout abort path.
module tb_mem_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mem_wr, load_signed, bus_ack;
  logic [1:0]  size;
  logic [31:0] addr, wdata, bus_rdata;
  logic        busy, done, err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  logic        start_t, ack_t;
  logic        busy_t, done_t, err_t, bus_req_t, bus_we_t;
  logic [31:0] rdata_t, bus_addr_t, bus_wdata_t;
  logic [3:0]  bus_be_t;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_align_unit dut (
    .clk(clk), .rst(rst), .start(start), .mem_wr(mem_wr), .size(size),
    .load_signed(load_signed), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .err(err), .rdata(rdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  mem_align_unit #(.TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst), .start(start_t), .mem_wr(mem_wr), .size(size),
    .load_signed(load_signed), .addr(addr), .wdata(wdata), .busy(busy_t),
    .done(done_t), .err(err_t), .rdata(rdata_t), .bus_req(bus_req_t),
    .bus_we(bus_we_t), .bus_addr(bus_addr_t), .bus_be(bus_be_t),
    .bus_wdata(bus_wdata_t), .bus_ack(ack_t), .bus_rdata(bus_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  // Runs one aligned access on the main instance with a given number of wait
  // cycles before ack; optionally pulses a stray start while busy.
  task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] sz,
                               input logic sg, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input int waits,
                               input logic [3:0] exp_be, input logic [31:0] exp_wd,
                               input logic [31:0] exp_rdata, input logic stray);
    int req_cycles = 0;
    int done_count = 0;
    @(negedge clk);
    mem_wr = wr; size = sz; load_signed = sg; addr = a; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < waits; c++) begin
      if (bus_req) req_cycles++;
      if (done) done_count++;
      if (c == 0) begin
        checkOutput({tag, ".addr"}, bus_addr, {a[31:2], 2'b00});
        checkOutput({tag, ".be"}, {28'd0, bus_be}, {28'd0, exp_be});
        checkOutput({tag, ".we"}, {31'd0, bus_we}, {31'd0, wr});
        checkOutput({tag, ".wdata"}, bus_wdata, exp_wd);
      end
      if (stray && c == 1) begin
        addr = 32'h0000_5555; size = 2'b00; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (bus_req) req_cycles++;
    checkOutput({tag, ".be_hold"}, {28'd0, bus_be}, {28'd0, exp_be});
    checkOutput({tag, ".addr_hold"}, bus_addr, {a[31:2], 2'b00});
    bus_ack = 1'b1; bus_rdata = rd;
    @(negedge clk);
    bus_ack = 1'b0;
    checkOutput({tag, ".req_cycles"}, req_cycles, waits + 1);
    checkOutput({tag, ".done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, ".err"}, {31'd0, err}, 32'd0);
    checkOutput({tag, ".rdata"}, rdata, exp_rdata);
    if (done) done_count++;
    @(negedge clk);
    if (done) done_count++;
    checkOutput({tag, ".done_once"}, done_count, 1);
    checkOutput({tag, ".idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic misalignedAccess(input string tag, input logic [1:0] sz, input logic [31:0] a,
                                  input logic [31:0] exp_rdata);
    @(negedge clk);
    mem_wr = 1'b0; size = sz; load_signed = 1'b0; addr = a; start = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    bus_ack = 1'b1;
    checkOutput({tag, ".req"}, {31'd0, bus_req}, 32'd0);
    checkOutput({tag, ".done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, ".err"}, {31'd0, err}, 32'd1);
    checkOutput({tag, ".busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    bus_ack = 1'b0;
    checkOutput({tag, ".done_off"}, {31'd0, done}, 32'd0);
    checkOutput({tag, ".busy_off"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, ".rdata"}, rdata, exp_rdata);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; start_t = 1'b0; ack_t = 1'b0; mem_wr = 1'b0;
    size = 2'b00; load_signed = 1'b0; addr = 32'd0; wdata = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    #12;
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkOutput("reset.done", {31'd0, done}, 32'd0);
    checkOutput("reset.req", {31'd0, bus_req}, 32'd0);
    checkOutput("reset.be", {28'd0, bus_be}, 32'd0);
    checkOutput("reset.rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("st_byte", 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'hAABB_CC5A, 32'd0, 0,
                  4'b1000, 32'h5A5A_5A5A, 32'd0, 1'b0);
    applyStimulus("ld_half_s", 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0,
                  4'b1111, 32'h0, 32'hFFFF_8001, 1'b0);
    applyStimulus("ld_half_u", 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 0,
                  4'b1111, 32'h0, 32'h0000_8001, 1'b0);
    applyStimulus("ld_byte_s", 1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0, 32'h8001_1234, 0,
                  4'b1111, 32'h0, 32'h0000_0012, 1'b0);
    applyStimulus("st_half_hi", 1'b1, 2'b01, 1'b0, 32'h0000_4002, 32'h1234_BEEF, 32'd0, 1,
                  4'b1100, 32'hBEEF_BEEF, 32'h0000_0012, 1'b0);
    applyStimulus("ld_byte3_s", 1'b0, 2'b00, 1'b1, 32'h0000_4003, 32'h0, 32'h9A00_0000, 0,
                  4'b1111, 32'h0, 32'hFFFF_FF9A, 1'b0);
    applyStimulus("st_wait", 1'b1, 2'b10, 1'b0, 32'h0000_6000, 32'hCAFE_F00D, 32'd0, 5,
                  4'b1111, 32'hCAFE_F00D, 32'hFFFF_FF9A, 1'b1);
    applyStimulus("ld_word", 1'b0, 2'b10, 1'b0, 32'h0000_7004, 32'h0, 32'h1357_9BDF, 2,
                  4'b1111, 32'h0, 32'h1357_9BDF, 1'b0);

    misalignedAccess("mis_word", 2'b10, 32'h0000_3002, 32'h1357_9BDF);
    misalignedAccess("mis_half", 2'b01, 32'h0000_3001, 32'h1357_9BDF);
    misalignedAccess("mis_size", 2'b11, 32'h0000_3000, 32'h1357_9BDF);

    @(negedge clk);
    mem_wr = 1'b0; size = 2'b10; addr = 32'h0000_8000; start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    n = 0;
    while (bus_req_t && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput("timeout.req_cycles", n, 4);
    checkOutput("timeout.done", {31'd0, done_t}, 32'd1);
    checkOutput("timeout.err", {31'd0, err_t}, 32'd1);
    @(negedge clk);
    checkOutput("timeout.idle", {31'd0, busy_t}, 32'd0);

    @(negedge clk);
    mem_wr = 1'b0; size = 2'b10; addr = 32'h0000_9000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("rst_mid.req_before", {31'd0, bus_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid.req", {31'd0, bus_req}, 32'd0);
    checkOutput("rst_mid.busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mid.done", {31'd0, done}, 32'd0);
    checkOutput("rst_mid.addr", bus_addr, 32'd0);
    checkOutput("rst_mid.rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    checkOutput("rst_mid.no_done", {31'd0, done}, 32'd0);
    checkOutput("rst_mid.idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_align_unit.md
# mem_align_unit

Data-memory access unit for the MEM stage. It takes a 32-bit address, 32-bit store data, and an access size from the pipeline, then runs one request/acknowledge transaction on the word-wide data bus. Stores are narrowed: the byte or halfword is truncated and replicated into the addressed lane with byte enables. Loads do the reverse: the addressed lane is extracted and sign- or zero-extended back to 32 bits.

## Interface

Parameters:
- TIMEOUT, default 255: maximum REQ-state cycles without bus_ack before the access aborts with an error; 8-bit counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  access request pulse; accepted only when busy=0
- mem_wr  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- load_signed  in  1  1 = sign-extend load result, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data; low byte/half used for narrow stores
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, on misalignment/illegal size/timeout
- rdata  out  32  extended load result; holds until next successful load
- bus_req  out  1  bus request; held high until acknowledged
- bus_we  out  1  write strobe qualifier
- bus_addr  out  32  {addr[31:2], 2'b00}
- bus_be  out  4  byte enables, bit i = bits [8i+7:8i]
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus acknowledge; bus_rdata valid in same cycle
- bus_rdata  in  32  read word

## Operation

- FSM states: IDLE, REQ, DONE, ERR.
  - IDLE: on start, capture mem_wr, size, load_signed, addr[1:0], and the formatted bus fields.
    - If misaligned → ERR. Misaligned means: size 11, half with addr[0]=1, or word with addr[1:0]≠0.
    - Otherwise → REQ, with the timeout counter cleared.
  - REQ: bus_req=1 and bus fields stable.
    - bus_ack=1 → DONE; for loads, rdata is updated at this same edge.
    - Counter reaches TIMEOUT-1 without ack → ERR.
    - Otherwise counter+1.
  - DONE: done=1 → IDLE.
  - ERR: done=1, err=1 → IDLE. No bus transaction is issued (misalignment), or it is abandoned (timeout). rdata is unchanged.
- Store formatting, little-endian lanes:
  - byte: bus_wdata={4{wdata[7:0]}}, bus_be=4'b0001<<addr[1:0].
  - half: bus_wdata={2{wdata[15:0]}}, bus_be=addr[1]?4'b1100:4'b0011.
  - word: wdata, 4'b1111.
- Load formatting:
  - byte: lane bus_rdata[8*addr[1:0]+:8], extended per load_signed.
  - half: bus_rdata[16*addr[1]+:16], extended.
  - word: unmodified.
  - Loads drive bus_be=4'b1111 and bus_we=0.
- start while busy=1 is ignored; there is no queueing.
- bus_ack outside REQ is ignored.

## Timing

- Reset (async, immediate): state IDLE, busy=0, done=0, err=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, rdata=0, counter=0.
- Reset mid-transaction: bus_req drops asynchronously and the access is lost. There is no done pulse.
- Latency, with start sampled at edge 0:
  - bus_req high from edge 0 to the edge where bus_ack is sampled (edge k, k≥1).
  - done high for the cycle after edge k.
  - Zero-wait bus (ack in first REQ cycle) gives done in cycle 2; next start accepted in the cycle after done.
- Misaligned access: busy and err/done high for exactly one cycle following the start edge.
- Timeout: ERR is entered after exactly TIMEOUT REQ cycles without ack. bus_req falls at that edge.
- bus_addr/bus_be/bus_we/bus_wdata are registered at accept. They change only on the next accepted start.

## Test plan

- Store byte, addr=0x1003, wdata=0xAABBCC5A, ack in first REQ cycle → bus_addr=0x1000, bus_be=4'b1000, bus_wdata=0x5A5A5A5A, bus_we=1, done in cycle 2, err=0.
- Load half signed, addr=0x2002, bus_rdata=0x8001_1234 → rdata=0xFFFF8001. Same access unsigned → 0x00008001. Byte signed at addr 0x2001 → 0x00000012.
- Misaligned word, addr=0x3002 (also half at 0x3001, and size=11) → no bus_req, done=err=1 one cycle after start, rdata unchanged.
- Wait states: ack delayed 5 cycles → bus_req held 6 cycles with stable fields. A start pulsed during busy is ignored. done occurs once.
- Timeout with TIMEOUT=4, no ack → bus_req high 4 cycles, then done=err=1. Assert rst during a REQ → bus_req=0 immediately, all outputs at reset values, no done.
